// File: rtl/decoder_rr_arbiter_if.sv
// Request/grant bundle for decoder_rr_arbiter.
// master: requester side (drives req/done); slave: arbiter side (drives grant outputs).
interface decoder_rr_arbiter_if;
  logic [15:0] req;
  logic        done;
  logic        gnt_valid;
  logic [3:0]  gnt_idx;
  logic [15:0] gnt_onehot;
  logic        timeout;

  modport master (
    output req,
    output done,
    input  gnt_valid,
    input  gnt_idx,
    input  gnt_onehot,
    input  timeout
  );

  modport slave (
    input  req,
    input  done,
    output gnt_valid,
    output gnt_idx,
    output gnt_onehot,
    output timeout
  );
endinterface

// File: rtl/decoder_rr_arbiter.sv
// 16-way round-robin arbiter with a registered binary + one-hot grant.
// Each grant is followed by one RELEASE cycle and one IDLE arbitration cycle.
// Optional hold-time limit: define ARB_TIMEOUT_EN to revoke a grant after HOLD_MAX cycles
// and pulse timeout; without it timeout is tied low and grants last until released.
module decoder_rr_arbiter #(
  parameter int unsigned HOLD_MAX = 15
) (
  input logic                  clk,
  input logic                  rst,
  decoder_rr_arbiter_if.slave  bus
);

  typedef enum logic [1:0] {StIdle, StGrant, StRelease} state_e;

  state_e      r_state, w_state_next;
  logic [3:0]  r_ptr, w_ptr_next;
  logic        r_gnt_valid, w_gnt_valid_next;
  logic [3:0]  r_gnt_idx, w_gnt_idx_next;
  logic [15:0] r_gnt_onehot, w_gnt_onehot_next;

  logic [3:0]  w_winner;
  logic [3:0]  w_cand;
  logic        w_found;
  logic        w_release;

`ifdef ARB_TIMEOUT_EN
  localparam logic [7:0] HoldLast = 8'(HOLD_MAX - 1);

  logic [7:0]  r_hold_cnt, w_hold_cnt_next;
  logic        r_timeout, w_timeout_next;
`endif

  // Round-robin scan: first set request at or above r_ptr, wrapping 15 -> 0.
  always_comb begin
    w_winner = r_ptr;
    w_cand   = r_ptr;
    w_found  = 1'b0;
    for (int i = 0; i < 16; i++) begin
      w_cand = r_ptr + 4'(i);
      if (!w_found && bus.req[w_cand]) begin
        w_winner = w_cand;
        w_found  = 1'b1;
      end
    end
  end

  // Holder gives up the resource: explicit done or its own request dropped.
  assign w_release = bus.done | ~bus.req[r_gnt_idx];

  // Next-state and next registered outputs.
  always_comb begin
    w_state_next   = r_state;
    w_ptr_next     = r_ptr;
    w_gnt_idx_next = 4'd0;
`ifdef ARB_TIMEOUT_EN
    w_hold_cnt_next = r_hold_cnt;
    w_timeout_next  = 1'b0;
`endif
    unique case (r_state)
      StIdle: begin
        if (w_found) begin
          w_state_next   = StGrant;
          w_gnt_idx_next = w_winner;
`ifdef ARB_TIMEOUT_EN
          w_hold_cnt_next = 8'd0;
`endif
        end
      end
      StGrant: begin
        if (w_release) begin
          // done wins over a simultaneous hold-limit expiry, so no timeout pulse here.
          w_state_next = StRelease;
          w_ptr_next   = r_gnt_idx + 4'd1;
`ifdef ARB_TIMEOUT_EN
        end else if (r_hold_cnt == HoldLast) begin
          w_state_next   = StRelease;
          w_ptr_next     = r_gnt_idx + 4'd1;
          w_timeout_next = 1'b1;
`endif
        end else begin
          w_gnt_idx_next = r_gnt_idx;
`ifdef ARB_TIMEOUT_EN
          w_hold_cnt_next = r_hold_cnt + 8'd1;
`endif
        end
      end
      StRelease: begin
        // Requests and done are ignored here; arbitration resumes from IDLE.
        w_state_next = StIdle;
      end
      default: begin
        w_state_next = StIdle;
      end
    endcase
    w_gnt_valid_next  = (w_state_next == StGrant);
    w_gnt_onehot_next = w_gnt_valid_next ? (16'd1 << w_gnt_idx_next) : 16'd0;
  end

  // State and output registers; reset drops any grant immediately.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= StIdle;
      r_ptr        <= 4'd0;
      r_gnt_valid  <= 1'b0;
      r_gnt_idx    <= 4'd0;
      r_gnt_onehot <= 16'd0;
    end else begin
      r_state      <= w_state_next;
      r_ptr        <= w_ptr_next;
      r_gnt_valid  <= w_gnt_valid_next;
      r_gnt_idx    <= w_gnt_idx_next;
      r_gnt_onehot <= w_gnt_onehot_next;
    end
  end

`ifdef ARB_TIMEOUT_EN
  // Hold counter and timeout pulse register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_hold_cnt <= 8'd0;
      r_timeout  <= 1'b0;
    end else begin
      r_hold_cnt <= w_hold_cnt_next;
      r_timeout  <= w_timeout_next;
    end
  end

  assign bus.timeout = r_timeout;
`else
  assign bus.timeout = 1'b0;
`endif

  assign bus.gnt_valid  = r_gnt_valid;
  assign bus.gnt_idx    = r_gnt_idx;
  assign bus.gnt_onehot = r_gnt_onehot;

endmodule

// File: tb/tb_decoder_rr_arbiter.sv
// Scoreboard bench for decoder_rr_arbiter: a behavioural model predicts each cycle's
// registered outputs, which are queued on drive and compared after the next clock edge.
module tb_decoder_rr_arbiter;

  localparam int TB_HOLD = 4;

  typedef struct packed {
    logic        v;
    logic [3:0]  idx;
    logic [15:0] oh;
    logic        to;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b0;

  decoder_rr_arbiter_if bus ();

  decoder_rr_arbiter #(
    .HOLD_MAX (TB_HOLD)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int   n_checks = 0;
  int   n_fail   = 0;
  exp_t sb_q[$];

  // Model state
  int         m_state;  // 0 idle, 1 grant, 2 release
  logic [3:0] m_ptr;
  logic [3:0] m_idx;
  int         m_cnt;

  // Observation logs
  int   g_idx[$];
  int   g_gap[$];
  int   g_len[$];
  int   idle_run;
  int   cur_len;
  int   t_count;
  logic prev_valid;
  int   waitc[16];
  int   max_wait;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  function automatic int q_at(input int q[$], input int i);
    return (i < q.size()) ? q[i] : -1;
  endfunction

  task automatic model_reset();
    m_state = 0;
    m_ptr   = 4'd0;
    m_idx   = 4'd0;
    m_cnt   = 0;
  endtask

  task automatic clear_logs();
    g_idx.delete();
    g_gap.delete();
    g_len.delete();
    idle_run   = 0;
    cur_len    = 0;
    t_count    = 0;
    prev_valid = 1'b0;
    for (int i = 0; i < 16; i++) waitc[i] = 0;
    max_wait = 0;
  endtask

  task automatic model_step(input logic [15:0] r, input logic d, output exp_t e);
    int w;
    int j;
    e = '0;
    w = -1;
    case (m_state)
      0: begin
        for (int k = 0; k < 16; k++) begin
          j = (int'(m_ptr) + k) % 16;
          if (w < 0 && r[j]) w = j;
        end
        if (w >= 0) begin
          m_state = 1;
          m_idx   = 4'(w);
          m_cnt   = 0;
        end
      end
      1: begin
        if (d || !r[m_idx]) begin
          m_ptr   = m_idx + 4'd1;
          m_state = 2;
        end
`ifdef ARB_TIMEOUT_EN
        else if (m_cnt == TB_HOLD - 1) begin
          m_ptr   = m_idx + 4'd1;
          m_state = 2;
          e.to    = 1'b1;
        end
`endif
        else begin
          m_cnt++;
        end
      end
      default: m_state = 0;
    endcase
    if (m_state == 1) begin
      e.v   = 1'b1;
      e.idx = m_idx;
      e.oh  = 16'd1 << m_idx;
    end
  endtask

  // One clock: drive inputs, queue the prediction, compare after the edge.
  task automatic run_cycle(input logic [15:0] r, input logic d);
    exp_t e;
    bus.req  = r;
    bus.done = d;
    model_step(r, d, e);
    sb_q.push_back(e);
    @(posedge clk);
    #1;
    e = sb_q.pop_front();
    check_eq("gnt_valid", 32'(bus.gnt_valid), 32'(e.v));
    check_eq("gnt_idx", 32'(bus.gnt_idx), 32'(e.idx));
    check_eq("gnt_onehot", 32'(bus.gnt_onehot), 32'(e.oh));
    check_eq("timeout", 32'(bus.timeout), 32'(e.to));
    check_eq("onehot_at_most_one", 32'($countones(bus.gnt_onehot) <= 1), 32'd1);
    for (int i = 0; i < 16; i++) if (!r[i]) waitc[i] = 0;
    t_count += int'(bus.timeout);
    if (bus.gnt_valid) begin
      if (!prev_valid) begin
        g_idx.push_back(int'(bus.gnt_idx));
        g_gap.push_back(idle_run);
        cur_len = 0;
        for (int i = 0; i < 16; i++) begin
          if (i == int'(bus.gnt_idx)) waitc[i] = 0;
          else if (r[i]) begin
            waitc[i]++;
            if (waitc[i] > max_wait) max_wait = waitc[i];
          end
        end
      end
      cur_len++;
      idle_run = 0;
    end else begin
      if (prev_valid) g_len.push_back(cur_len);
      idle_run++;
    end
    prev_valid = bus.gnt_valid;
  endtask

  task automatic do_reset();
    bus.req  = 16'd0;
    bus.done = 1'b0;
    rst      = 1'b1;
    #1;
    check_eq("rst_gnt_valid", 32'(bus.gnt_valid), 32'd0);
    check_eq("rst_gnt_idx", 32'(bus.gnt_idx), 32'd0);
    check_eq("rst_gnt_onehot", 32'(bus.gnt_onehot), 32'd0);
    check_eq("rst_timeout", 32'(bus.timeout), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
    sb_q.delete();
    clear_logs();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] rq;
    bus.req  = 16'd0;
    bus.done = 1'b0;
    model_reset();
    clear_logs();
    #2;

    // Single requester after reset: one-cycle latency, index 0.
    do_reset();
    run_cycle(16'h0001, 1'b0);
    check_eq("first_valid", 32'(bus.gnt_valid), 32'd1);
    check_eq("first_idx", 32'(bus.gnt_idx), 32'd0);
    check_eq("first_onehot", 32'(bus.gnt_onehot), 32'h0001);

    // Two requesters, done in each grant's first cycle: 0,15,0,15 with 2-cycle gaps.
    do_reset();
    for (int n = 0; n < 12; n++) run_cycle(16'h8001, m_state == 1);
    check_eq("alt_count", 32'(g_idx.size() >= 4), 32'd1);
    check_eq("alt_g0", 32'(q_at(g_idx, 0)), 32'd0);
    check_eq("alt_g1", 32'(q_at(g_idx, 1)), 32'd15);
    check_eq("alt_g2", 32'(q_at(g_idx, 2)), 32'd0);
    check_eq("alt_g3", 32'(q_at(g_idx, 3)), 32'd15);
    check_eq("alt_gap1", 32'(q_at(g_gap, 1)), 32'd2);
    check_eq("alt_gap2", 32'(q_at(g_gap, 2)), 32'd2);
    check_eq("alt_gap3", 32'(q_at(g_gap, 3)), 32'd2);

    // Pointer wrap: grant 15, then requests on 15 and 1 -> next grant is 1.
    do_reset();
    run_cycle(16'h8000, 1'b0);
    check_eq("wrap_g15", 32'(bus.gnt_idx), 32'd15);
    run_cycle(16'h8002, 1'b1);
    check_eq("wrap_release", 32'(bus.gnt_valid), 32'd0);
    run_cycle(16'h8002, 1'b1);
    run_cycle(16'h8002, 1'b0);
    check_eq("wrap_valid", 32'(bus.gnt_valid), 32'd1);
    check_eq("wrap_idx", 32'(bus.gnt_idx), 32'd1);

    // Asynchronous reset in the middle of a grant to index 3.
    do_reset();
    run_cycle(16'h0008, 1'b0);
    check_eq("pre_arst_idx", 32'(bus.gnt_idx), 32'd3);
    #3;
    rst = 1'b1;
    #1;
    check_eq("arst_valid", 32'(bus.gnt_valid), 32'd0);
    check_eq("arst_onehot", 32'(bus.gnt_onehot), 32'd0);
    check_eq("arst_idx", 32'(bus.gnt_idx), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
    sb_q.delete();
    clear_logs();
    run_cycle(16'h0009, 1'b0);
    check_eq("post_arst_idx", 32'(bus.gnt_idx), 32'd0);
    check_eq("post_arst_valid", 32'(bus.gnt_valid), 32'd1);

`ifdef ARB_TIMEOUT_EN
    // Persistent single requester: revoked after TB_HOLD cycles, re-granted 2 cycles later.
    do_reset();
    for (int n = 0; n < 14; n++) run_cycle(16'h0010, 1'b0);
    check_eq("to_len0", 32'(q_at(g_len, 0)), 32'(TB_HOLD));
    check_eq("to_regrant_idx", 32'(q_at(g_idx, 1)), 32'd4);
    check_eq("to_regrant_gap", 32'(q_at(g_gap, 1)), 32'd2);
    check_eq("to_pulses", 32'(t_count), 32'd2);

    // done on the last allowed cycle: released without a timeout pulse.
    do_reset();
    for (int n = 0; n < TB_HOLD; n++) run_cycle(16'h0010, 1'b0);
    run_cycle(16'h0010, 1'b1);
    check_eq("done_prio_valid", 32'(bus.gnt_valid), 32'd0);
    check_eq("done_prio_timeout", 32'(bus.timeout), 32'd0);
    check_eq("done_prio_pulses", 32'(t_count), 32'd0);
`else
    // No hold limit: a persistent holder keeps the grant.
    do_reset();
    for (int n = 0; n < 40; n++) run_cycle(16'h0010, 1'b0);
    check_eq("hold_valid", 32'(bus.gnt_valid), 32'd1);
    check_eq("hold_idx", 32'(bus.gnt_idx), 32'd4);
    check_eq("hold_grants", 32'(g_idx.size()), 32'd1);
    check_eq("hold_pulses", 32'(t_count), 32'd0);
`endif

    // Random traffic: requests stay up until served; holder releases randomly.
    do_reset();
    rq = 16'd0;
    for (int n = 0; n < 3000; n++) begin
      rq = rq | (16'($urandom) & 16'($urandom) & 16'($urandom));
      if (m_state == 1 && $urandom_range(0, 7) == 0) rq[m_idx] = 1'b0;
      if (m_state == 2 && $urandom_range(0, 1) == 0) rq[m_ptr - 4'd1] = 1'b0;
      run_cycle(rq, $urandom_range(0, 3) == 0);
    end
    check_eq("rand_grants_seen", 32'(g_idx.size() > 100), 32'd1);
    check_eq("rand_no_starvation", 32'(max_wait <= 15), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
